// File: rtl/mult_result_accum_pkg.sv
// Shared definitions for the product-frame accumulator and its upstream frame controller:
// state encoding, parameter legal ranges and the count-register sizing rule.
package mult_result_accum_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  localparam int ACC_LEN_MIN = 1;
  localparam int ACC_LEN_MAX = 256;
  localparam int OUT_W_MIN   = 8;
  localparam int OUT_W_MAX   = 24;

  // Count must reach ACC_LEN itself, so size for ACC_LEN+1 values; never below 1 bit.
  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/mult_result_accum_sat_add.sv
// Unsigned saturating adder: clamps to all-ones and flags overflow when the true sum
// does not fit in W bits.
module sat_add #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         overflow
);

  logic [W:0] full;

  always_comb begin
    full     = {1'b0, a} + {1'b0, b};
    overflow = full[W];
    sum      = full[W] ? {W{1'b1}} : full[W-1:0];
  end

endmodule

// File: rtl/mult_result_accum.sv
// Frame accumulator behind the 4x4 multiplier: sums ACC_LEN valid products with saturation
// and presents the result on a valid/ready port until the consumer takes it.
//
// Output handshake: o_sum/o_overflow are offered while o_sum_valid is high; a transfer happens
// on a rising clkb edge where o_sum_valid && i_sum_ready. o_sum_valid is a register, never
// a function of i_sum_ready, and only a transfer or rst can drop it.
module mult_result_accum
  import mult_result_accum_pkg::*;
#(
  parameter int ACC_LEN = 8,
  parameter int OUT_W   = 16
) (
  input  logic             clkb,
  input  logic             rst,
  input  logic             i_start,
  input  logic [7:0]       i_result,
  input  logic             i_valid,
  output logic             o_busy,
  output logic [OUT_W-1:0] o_sum,
  output logic             o_sum_valid,
  input  logic             i_sum_ready,
  output logic             o_overflow,
  output logic [1:0]       o_state
);

  localparam int CNT_W = cnt_width(ACC_LEN);

  logic [1:0]       state;
  logic [OUT_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic [OUT_W-1:0] add_sum;
  logic             add_ovf;
  logic             last_product;

  sat_add #(.W(OUT_W)) u_sat_add (
    .a        (acc),
    .b        (OUT_W'(i_result)),
    .sum      (add_sum),
    .overflow (add_ovf)
  );

  assign last_product = (cnt == CNT_W'(ACC_LEN - 1));
  assign o_busy       = (state != ST_IDLE);
  assign o_state      = state;

  always_ff @(posedge clkb) begin
    if (rst) begin
      state       <= ST_IDLE;
      acc         <= '0;
      cnt         <= '0;
      o_sum       <= '0;
      o_sum_valid <= 1'b0;
      o_overflow  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            acc        <= '0;
            cnt        <= '0;
            o_overflow <= 1'b0;
            state      <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (i_valid) begin
            acc <= add_sum;
            cnt <= cnt + CNT_W'(1);
            // Sticky: once any partial sum clamps, the frame is marked saturated.
            if (add_ovf) o_overflow <= 1'b1;
            if (last_product) begin
              o_sum       <= add_sum;
              o_sum_valid <= 1'b1;
              state       <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (i_sum_ready) begin
            o_sum_valid <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_result_accum.sv
// Bench for mult_result_accum: two instances (ACC_LEN=4/OUT_W=16 and ACC_LEN=8/OUT_W=10),
// a per-cycle frame-level reference and directed frames with literal expected sums.
module tb_mult_result_accum;
  import mult_result_accum_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       start [2];
  logic       valid [2];
  logic       ready [2];
  logic [7:0] result [2];

  logic        busy [2];
  logic        sum_valid [2];
  logic        ovf [2];
  logic [1:0]  state [2];
  logic [15:0] sum_a;
  logic [9:0]  sum_b;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mult_result_accum #(.ACC_LEN(4), .OUT_W(16)) dut_a (
    .clkb(clk), .rst(rst), .i_start(start[0]), .i_result(result[0]), .i_valid(valid[0]),
    .o_busy(busy[0]), .o_sum(sum_a), .o_sum_valid(sum_valid[0]), .i_sum_ready(ready[0]),
    .o_overflow(ovf[0]), .o_state(state[0])
  );

  mult_result_accum #(.ACC_LEN(8), .OUT_W(10)) dut_b (
    .clkb(clk), .rst(rst), .i_start(start[1]), .i_result(result[1]), .i_valid(valid[1]),
    .o_busy(busy[1]), .o_sum(sum_b), .o_sum_valid(sum_valid[1]), .i_sum_ready(ready[1]),
    .o_overflow(ovf[1]), .o_state(state[1])
  );

  function automatic int get_sum(input int d);
    return (d == 0) ? int'(sum_a) : int'(sum_b);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference: a frame is a window that opens on start, closes after len valid products,
  // and its sum is the plain integer total clamped to the output range.
  int len [2]  = '{4, 8};
  int maxv [2] = '{65535, 1023};
  bit m_live   = 1'b0;
  bit m_open [2];
  bit m_pres [2];
  bit m_zero [2];
  int m_cnt [2];
  int m_total [2];
  int m_sum [2];
  bit m_ovf [2];

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_open[d] = 0; m_pres[d] = 0; m_zero[d] = 1;
        m_cnt[d] = 0; m_total[d] = 0; m_sum[d] = 0; m_ovf[d] = 0;
      end else if (m_pres[d]) begin
        if (ready[d]) m_pres[d] = 0;
      end else if (m_open[d]) begin
        if (valid[d]) begin
          m_total[d] += int'(result[d]);
          m_cnt[d]++;
          if (m_cnt[d] == len[d]) begin
            m_sum[d]  = (m_total[d] > maxv[d]) ? maxv[d] : m_total[d];
            m_ovf[d]  = (m_total[d] > maxv[d]);
            m_open[d] = 0;
            m_pres[d] = 1;
          end
        end
      end else if (start[d]) begin
        m_open[d] = 1; m_zero[d] = 0; m_cnt[d] = 0; m_total[d] = 0;
      end
    end
    if (rst) m_live = 1'b1;
  end

  always @(negedge clk) begin
    if (m_live) begin
      for (int d = 0; d < 2; d++) begin
        check($sformatf("busy[%0d]", d), int'(busy[d]), int'(m_open[d] | m_pres[d]));
        check($sformatf("sum_valid[%0d]", d), int'(sum_valid[d]), int'(m_pres[d]));
        check($sformatf("state[%0d]", d), int'(state[d]),
              m_pres[d] ? int'(ST_HOLD) : (m_open[d] ? int'(ST_ACCUM) : int'(ST_IDLE)));
        if (m_pres[d] || m_zero[d]) begin
          check($sformatf("sum[%0d]", d), get_sum(d), m_zero[d] ? 0 : m_sum[d]);
          check($sformatf("overflow[%0d]", d), int'(ovf[d]), m_zero[d] ? 0 : int'(m_ovf[d]));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int vec[$];

  // Start pulse, then each product of vec preceded by `gap` non-valid cycles.
  task automatic send_frame(input int d, input int gap, input bit fill_ff);
    start[d] = 1'b1;
    tick();
    start[d] = 1'b0;
    foreach (vec[i]) begin
      for (int g = 0; g < gap; g++) begin
        valid[d]  = 1'b0;
        result[d] = fill_ff ? 8'hFF : 8'($urandom_range(0, 255));
        tick();
      end
      valid[d]  = 1'b1;
      result[d] = 8'(vec[i]);
      tick();
    end
    valid[d]  = 1'b0;
    result[d] = 8'h00;
  endtask

  task automatic expect_sum(input int d, input string name, input int exp_sum, input int exp_ovf);
    int waited = 0;
    while (!sum_valid[d] && waited < 20) begin
      tick();
      waited++;
    end
    check({name, "_valid"}, int'(sum_valid[d]), 1);
    check({name, "_latency"}, waited, 0);
    check({name, "_sum"}, get_sum(d), exp_sum);
    check({name, "_ovf"}, int'(ovf[d]), exp_ovf);
    check({name, "_model"}, m_sum[d], exp_sum);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      start[d] = 0; valid[d] = 0; ready[d] = 0; result[d] = 0;
    end
    rst = 1'b1;
    tick();

    // Reset with random inputs for 2 cycles
    for (int c = 0; c < 2; c++) begin
      for (int d = 0; d < 2; d++) begin
        start[d]  = 1'($urandom_range(0, 1));
        valid[d]  = 1'($urandom_range(0, 1));
        ready[d]  = 1'($urandom_range(0, 1));
        result[d] = 8'($urandom_range(0, 255));
      end
      tick();
    end
    for (int d = 0; d < 2; d++) begin
      start[d] = 0; valid[d] = 0; ready[d] = 0; result[d] = 0;
    end
    rst = 1'b0;
    tick();
    check("reset_busy", int'(busy[0]), 0);
    check("reset_sum", get_sum(0), 0);
    check("reset_state", int'(state[0]), int'(ST_IDLE));

    // Valid pulses in IDLE must not leak into the next frame
    for (int c = 0; c < 3; c++) begin
      valid[0] = 1'b1; result[0] = 8'd50;
      tick();
    end
    valid[0] = 1'b0;
    check("idle_valid_busy", int'(busy[0]), 0);

    // Basic frame 3,5,7,9 with ready held high
    ready[0] = 1'b1;
    vec = '{3, 5, 7, 9};
    send_frame(0, 0, 1'b0);
    expect_sum(0, "basic", 24, 0);
    tick();
    check("basic_one_cycle", int'(sum_valid[0]), 0);

    // Same frame with gaps and 0xFF on non-valid cycles
    vec = '{3, 5, 7, 9};
    send_frame(0, 2, 1'b1);
    expect_sum(0, "gaps", 24, 0);
    tick();

    // Backpressure: hold ready low while toggling start/valid
    ready[0] = 1'b0;
    vec = '{1, 2, 3, 4};
    send_frame(0, 1, 1'b0);
    expect_sum(0, "bp", 10, 0);
    for (int c = 0; c < 5; c++) begin
      start[0]  = 1'(c & 1);
      valid[0]  = 1'(~c & 1);
      result[0] = 8'($urandom_range(0, 255));
      tick();
      check("bp_hold_sum", get_sum(0), 10);
      check("bp_hold_valid", int'(sum_valid[0]), 1);
    end
    ready[0] = 1'b1; start[0] = 1'b1; valid[0] = 1'b1;
    tick();
    start[0] = 1'b0; valid[0] = 1'b0;
    check("bp_release_state", int'(state[0]), int'(ST_IDLE));
    check("bp_release_busy", int'(busy[0]), 0);
    vec = '{4, 4, 4, 4};
    send_frame(0, 0, 1'b0);
    expect_sum(0, "bp_next", 16, 0);
    tick();

    // Saturation on the narrow instance, then a clean frame
    ready[1] = 1'b1;
    vec = '{225, 225, 225, 225, 225, 225, 225, 225};
    send_frame(1, 0, 1'b0);
    expect_sum(1, "sat", 1023, 1);
    tick();
    vec = '{1, 1, 1, 1, 1, 1, 1, 1};
    send_frame(1, 1, 1'b1);
    expect_sum(1, "sat_next", 8, 0);
    tick();

    // Reset after 2 of 4 products, then a fresh frame
    vec = '{10, 20};
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    foreach (vec[i]) begin
      valid[0] = 1'b1; result[0] = 8'(vec[i]);
      tick();
    end
    valid[0] = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy", int'(busy[0]), 0);
    check("midrst_state", int'(state[0]), int'(ST_IDLE));
    check("midrst_sum", get_sum(0), 0);
    check("midrst_valid", int'(sum_valid[0]), 0);
    vec = '{10, 20, 30, 40};
    send_frame(0, 0, 1'b0);
    expect_sum(0, "fresh", 100, 0);
    tick();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mult_result_accum.md
# mult_result_accum

Frame accumulator that sits directly downstream of the 4x4 multiplier in the `clkb` domain. It sums a fixed-length frame of 8-bit products into a wider register with saturation. It then presents the frame sum on a valid/ready output port and holds it until the consumer accepts it. An upstream controller delimits frames with a start pulse and a per-product valid.

## Interface
- `ACC_LEN`, 8: products per frame; legal range 1..256.
- `OUT_W`, 16: accumulator and sum width; legal range 8..24. The default cannot overflow for any `ACC_LEN` ≤ 256.
- `clkb`  in  1  single clock; all logic is on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `i_start`  in  1  begin a new frame; honoured only in IDLE.
- `i_result`  in  8  unsigned product from the multiplier.
- `i_valid`  in  1  `i_result` is meaningful this cycle.
- `o_busy`  out  1  high in ACCUM and HOLD.
- `o_sum`  out  OUT_W  frame sum, saturated.
- `o_sum_valid`  out  1  `o_sum` is presented.
- `i_sum_ready`  in  1  consumer accepts `o_sum`.
- `o_overflow`  out  1  the frame saturated; meaningful while `o_sum_valid` is high.

## Operation
- **States:** IDLE, ACCUM, HOLD.
- **IDLE:**
  - `o_busy`=0 and `o_sum_valid`=0.
  - `i_valid` is ignored.
  - `i_start`=1 clears the accumulator, the product count and `o_overflow`, then moves to ACCUM.
- **ACCUM:**
  - Each cycle with `i_valid`=1: acc ← sat(acc + zero-extended `i_result`), and count increments.
  - Saturation: if the true sum exceeds 2^OUT_W−1, acc holds at 2^OUT_W−1 and `o_overflow` sets. `o_overflow` is sticky for the frame.
  - Cycles with `i_valid`=0 leave acc and count unchanged, whatever the value of `i_result`.
  - When the accepted product is the ACC_LEN-th, the saturated final sum is registered into `o_sum`, `o_sum_valid` is set and the block moves to HOLD.
  - `i_start` is ignored in ACCUM.
- **HOLD:**
  - `o_sum`, `o_sum_valid` and `o_overflow` stay stable until `i_sum_ready`=1.
  - On the handshake cycle the block moves to IDLE.
  - `i_start` and `i_valid` are ignored in HOLD, including on the handshake cycle.
- **Data width rules:**
  - Inputs are unsigned and zero-extended to OUT_W.
  - No wrap-around is ever produced; saturation is the only overflow behaviour.
- **Reset:**
  - In any state, including mid-frame or in HOLD, `rst` returns the block to IDLE.
  - acc, count, `o_sum`, `o_sum_valid`, `o_overflow` and `o_busy` all go to 0.
  - Any partial frame is discarded.
- **ACC_LEN=1:** the first valid product completes the frame.

## Timing
- **Reset values:** every output is 0.
- **Start:** `i_start` sampled in IDLE at edge N gives `o_busy`=1 from cycle N+1. A product with `i_valid` in cycle N+1 is the first one accepted.
- **Latency:** `o_sum_valid` rises on the cycle after the edge that accepts the ACC_LEN-th product.
- **Handshake:** `o_sum_valid` falls on the cycle after the edge where `o_sum_valid`&`i_sum_ready` is sampled. `o_busy` falls at the same time.
- **Valid/ready rules:**
  - `o_sum_valid` never depends combinationally on `i_sum_ready`.
  - Once asserted, `o_sum_valid` is not withdrawn before acceptance, except by reset.
- **Throughput:** the minimum frame period is ACC_LEN + 2 cycles: start, ACC_LEN products, one HOLD cycle with ready high, then the next start is accepted in IDLE.
- **Upstream contract:** the upstream controller aligns `i_valid` with the multiplier's 2-`clkb` operand-to-result latency. This block adds no alignment.

## Structure
- **Shared package:** holds the state encoding localparams (IDLE/ACCUM/HOLD, 2 bits) and the `ACC_LEN`/`OUT_W` legal-range constants. Reuse by the upstream frame controller.
- **Sub-module `sat_add`:** parameterised unsigned saturating adder of width OUT_W, producing sum and overflow outputs. It is combinational and instanced once.
- **Count register:** ceil(log2(ACC_LEN+1)) bits, minimum 1.

## Test plan
- **Reset:** assert `rst` for 2 cycles with random inputs. Required: all outputs 0, and `i_valid` pulses in IDLE leave the next frame's sum unaffected.
- **Basic frame:** `ACC_LEN`=4, `i_result` 3,5,7,9 on consecutive valid cycles, `i_sum_ready`=1. Required: `o_sum`=24 with `o_sum_valid` high for exactly 1 cycle, one cycle after the 9 is accepted, and `o_overflow`=0.
- **Valid gaps:** the same frame with idle cycles between products and `i_result`=0xFF on non-valid cycles. Required: `o_sum`=24.
- **Backpressure:** hold `i_sum_ready`=0 for 5 cycles while toggling `i_start` and `i_valid`. Required: `o_sum`, `o_sum_valid` and `o_overflow` stay stable. Raise ready and require IDLE the next cycle, with the following frame correct.
- **Saturation:** `OUT_W`=10, `ACC_LEN`=8, all products 225 (true sum 1800). Required: `o_sum`=1023 and `o_overflow`=1. A following frame of 1,1,...,1 must give `o_sum`=8 and `o_overflow`=0.
- **Reset mid-frame:** apply `rst` after 2 of 4 products. Required: outputs 0 the next cycle and state IDLE. A fresh frame 10,20,30,40 must give `o_sum`=100.
